cga_mode_init: RTL and testbench



---
 rtl/cga_mode_init.sv | 250 +++++++++++++++++++++++++
 tb/tb_cga_mode_init.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_mode_init.sv
// cga_mode_init: programs a CGA adapter over the ISA I/O bus without CPU help.
// On an accepted start the block optionally polls status (3DA bit3) for vertical
// retrace, then writes a fixed 35-entry register sequence for the selected mode:
// 3D8 (video off), CRTC R0..R15 through the 3D4/3D5 index/data pair, 3D8, 3D9.
//
// Ports:
//   clk, nRESET        clock, asynchronous active-low reset
//   start, mode        one-cycle request (sampled only when idle) and mode select
//   busy, done         sequence in progress / one-cycle completion pulse
//   timeout            sticky: retrace never seen within POLL_LIMIT status reads
//   bus_a, bus_d       I/O address and write data
//   bus_oe             write data driven (write ops only)
//   bus_din            read data from the adapter
//   bus_iow_l/ior_l    active-low I/O write/read strobes
//   bus_aen            low while an op is in progress, high when idle
module cga_mode_init #(
  parameter logic [15:0] IO_BASE_ADDR  = 16'h3D0,
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 2,
  parameter bit          WAIT_VRETRACE = 1'b1,
  parameter int unsigned POLL_LIMIT    = 1024
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        start,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [14:0] bus_a,
  output logic [7:0]  bus_d,
  output logic        bus_oe,
  input  logic [7:0]  bus_din,
  output logic        bus_iow_l,
  output logic        bus_ior_l,
  output logic        bus_aen
);

  localparam int unsigned PhMax = (SETUP_CYCLES > STROBE_CYCLES) ?
      ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
      ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int unsigned CntW  = $clog2(PhMax + 1);
  localparam int unsigned PollW = $clog2(POLL_LIMIT + 1);
  localparam logic [5:0]  LastStep = 6'd34;

  typedef enum logic [2:0] {
    StIdle, StPSetup, StPStrobe, StPHold, StWSetup, StWStrobe, StWHold, StFin
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [5:0]         step_q, step_d;
  logic [PollW-1:0]   poll_q, poll_d;
  logic [PollW-1:0]   poll_inc;
  logic [1:0]         mode_q, mode_d;
  logic               vr_q, vr_d;
  logic               timeout_q, timeout_d;
  logic [CntW-1:0]    ph_end;
  logic               ph_last;

  // CRTC values; the two graphics modes share one set, text modes differ in R0..R2
  function automatic logic [7:0] crtc_val(input logic [1:0] m, input logic [3:0] r);
    logic gfx;
    logic wide;
    gfx  = m[1];
    wide = (m == 2'd1);
    case (r)
      4'd0:    crtc_val = wide ? 8'h71 : 8'h38;
      4'd1:    crtc_val = wide ? 8'h50 : 8'h28;
      4'd2:    crtc_val = wide ? 8'h5A : 8'h2D;
      4'd3:    crtc_val = 8'h0A;
      4'd4:    crtc_val = gfx ? 8'h7F : 8'h1F;
      4'd5:    crtc_val = 8'h06;
      4'd6:    crtc_val = gfx ? 8'h64 : 8'h19;
      4'd7:    crtc_val = gfx ? 8'h70 : 8'h1C;
      4'd8:    crtc_val = 8'h02;
      4'd9:    crtc_val = gfx ? 8'h01 : 8'h07;
      4'd10:   crtc_val = 8'h06;
      4'd11:   crtc_val = 8'h07;
      default: crtc_val = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ctrl_val(input logic [1:0] m);
    case (m)
      2'd0:    ctrl_val = 8'h28;
      2'd1:    ctrl_val = 8'h29;
      2'd2:    ctrl_val = 8'h0A;
      default: ctrl_val = 8'h1A;
    endcase
  endfunction

  function automatic logic [7:0] color_val(input logic [1:0] m);
    color_val = (m == 2'd3) ? 8'h0F : 8'h30;
  endfunction

  // Phase length for the current op phase
  always_comb begin
    case (state_q)
      StPSetup, StWSetup:   ph_end = CntW'(SETUP_CYCLES - 1);
      StPStrobe, StWStrobe: ph_end = CntW'(STROBE_CYCLES - 1);
      default:              ph_end = CntW'(HOLD_CYCLES - 1);
    endcase
  end

  assign ph_last  = (cnt_q == ph_end);
  assign poll_inc = poll_q + PollW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = ph_last ? '0 : cnt_q + CntW'(1);
    step_d    = step_q;
    poll_d    = poll_q;
    mode_d    = mode_q;
    vr_d      = vr_q;
    timeout_d = timeout_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          mode_d    = mode;
          timeout_d = 1'b0;
          poll_d    = '0;
          step_d    = '0;
          vr_d      = 1'b0;
          state_d   = WAIT_VRETRACE ? StPSetup : StWSetup;
        end
      end
      StPSetup:  if (ph_last) state_d = StPStrobe;
      StPStrobe: begin
        if (ph_last) begin
          // Status is captured on the last strobe clock, when it has settled longest
          vr_d    = bus_din[3];
          state_d = StPHold;
        end
      end
      StPHold: begin
        if (ph_last) begin
          if (vr_q) begin
            state_d = StWSetup;
          end else begin
            poll_d = poll_inc;
            if (poll_inc == PollW'(POLL_LIMIT)) begin
              timeout_d = 1'b1;
              state_d   = StWSetup;
            end else begin
              state_d = StPSetup;
            end
          end
        end
      end
      StWSetup:  if (ph_last) state_d = StWStrobe;
      StWStrobe: if (ph_last) state_d = StWHold;
      StWHold: begin
        if (ph_last) begin
          if (step_q == LastStep) begin
            state_d = StFin;
          end else begin
            step_d  = step_q + 6'd1;
            state_d = StWSetup;
          end
        end
      end
      StFin: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      step_q    <= '0;
      poll_q    <= '0;
      mode_q    <= '0;
      vr_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      poll_q    <= poll_d;
      mode_q    <= mode_d;
      vr_q      <= vr_d;
      timeout_q <= timeout_d;
    end
  end

  // Write decode: step 0 blanks video, 1..32 alternate CRTC index/data, 33..34 restore
  logic [3:0]  wr_off;
  logic [7:0]  wr_data;
  logic [5:0]  crtc_idx;
  always_comb begin
    wr_off   = 4'h8;
    wr_data  = 8'h00;
    crtc_idx = step_q - 6'd1;
    if (step_q == 6'd0) begin
      wr_off  = 4'h8;
      wr_data = ctrl_val(mode_q) & 8'hF7;
    end else if (step_q <= 6'd32) begin
      if (!crtc_idx[0]) begin
        wr_off  = 4'h4;
        wr_data = {4'h0, crtc_idx[4:1]};
      end else begin
        wr_off  = 4'h5;
        wr_data = crtc_val(mode_q, crtc_idx[4:1]);
      end
    end else if (step_q == 6'd33) begin
      wr_off  = 4'h8;
      wr_data = ctrl_val(mode_q);
    end else begin
      wr_off  = 4'h9;
      wr_data = color_val(mode_q);
    end
  end

  // Bus outputs decode straight from state so an async reset idles the bus at once
  logic        in_poll;
  logic        in_write;
  logic [15:0] addr_full;
  assign in_poll  = (state_q == StPSetup) || (state_q == StPStrobe) || (state_q == StPHold);
  assign in_write = (state_q == StWSetup) || (state_q == StWStrobe) || (state_q == StWHold);

  always_comb begin
    addr_full = 16'h0000;
    if (in_poll) begin
      addr_full = IO_BASE_ADDR + 16'h000A;
    end else if (in_write) begin
      addr_full = IO_BASE_ADDR + {12'h000, wr_off};
    end
  end

  assign bus_a     = addr_full[14:0];
  assign bus_d     = in_write ? wr_data : 8'h00;
  assign bus_oe    = in_write;
  assign bus_iow_l = (state_q != StWStrobe);
  assign bus_ior_l = (state_q != StPStrobe);
  assign bus_aen   = !(in_poll || in_write);
  assign busy      = in_poll || in_write;
  assign done      = (state_q == StFin);
  assign timeout   = timeout_q;

  logic unused_bits;
  assign unused_bits = ^{bus_din[7:4], bus_din[2:0], addr_full[15]};

endmodule

// File: tb/tb_cga_mode_init.sv
// Bench for cga_mode_init. Two instances share clock and reset: dut0 writes
// immediately (no retrace wait), dut1 polls retrace with a 4-read limit. Only
// one instance is active at a time, so a single expected-op queue serves both.
module tb_cga_mode_init;

  localparam int S = 2;
  localparam int T = 4;
  localparam int H = 2;
  localparam int OpLen = S + T + H;
  localparam int NumWrites = 35;
  localparam int Latency = 1 + NumWrites * OpLen;

  logic        clk = 1'b0;
  logic        nRESET;
  logic        start     [2];
  logic [1:0]  mode      [2];
  logic        busy      [2];
  logic        done      [2];
  logic        timeout   [2];
  logic [14:0] bus_a     [2];
  logic [7:0]  bus_d     [2];
  logic        bus_oe    [2];
  logic [7:0]  bus_din   [2];
  logic        bus_iow_l [2];
  logic        bus_ior_l [2];
  logic        bus_aen   [2];

  always #5 clk = ~clk;

  cga_mode_init #(.WAIT_VRETRACE(1'b0)) u_dut0 (
    .clk(clk), .nRESET(nRESET), .start(start[0]), .mode(mode[0]), .busy(busy[0]),
    .done(done[0]), .timeout(timeout[0]), .bus_a(bus_a[0]), .bus_d(bus_d[0]),
    .bus_oe(bus_oe[0]), .bus_din(bus_din[0]), .bus_iow_l(bus_iow_l[0]),
    .bus_ior_l(bus_ior_l[0]), .bus_aen(bus_aen[0])
  );

  cga_mode_init #(.WAIT_VRETRACE(1'b1), .POLL_LIMIT(4)) u_dut1 (
    .clk(clk), .nRESET(nRESET), .start(start[1]), .mode(mode[1]), .busy(busy[1]),
    .done(done[1]), .timeout(timeout[1]), .bus_a(bus_a[1]), .bus_d(bus_d[1]),
    .bus_oe(bus_oe[1]), .bus_din(bus_din[1]), .bus_iow_l(bus_iow_l[1]),
    .bus_ior_l(bus_ior_l[1]), .bus_aen(bus_aen[1])
  );

  typedef struct packed {
    logic        k;
    logic        rd;
    logic [14:0] a;
    logic [7:0]  d;
  } op_t;

  op_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  ops_seen = 0;
  int  done_cnt [2];
  int  rd_cnt   [2];
  int  good_after [2];

  // Reference register tables, one row per mode
  logic [7:0] crtc_tbl [4][16] = '{
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
      8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
      8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70,
      8'h02, 8'h01, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70,
      8'h02, 8'h01, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00}
  };
  logic [7:0] ctrl_tbl  [4] = '{8'h28, 8'h29, 8'h0A, 8'h1A};
  logic [7:0] color_tbl [4] = '{8'h30, 8'h30, 8'h30, 8'h0F};

  // Adapter status model: bit3 appears from the good_after-th read of a run onwards
  assign bus_din[0] = (rd_cnt[0] >= good_after[0]) ? 8'hF8 : 8'hF0;
  assign bus_din[1] = (rd_cnt[1] >= good_after[1]) ? 8'hF8 : 8'hF0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [14:0] io_addr(input logic [3:0] off);
    logic [15:0] full;
    full = 16'h3D0 + {12'h000, off};
    return full[14:0];
  endfunction

  task automatic expect_seq(input int k, input int m, input int nreads, input int nwrites);
    logic [3:0] offs[$];
    logic [7:0] dats[$];
    op_t e;
    offs.push_back(4'h8); dats.push_back(ctrl_tbl[m] & 8'hF7);
    for (int r = 0; r < 16; r++) begin
      offs.push_back(4'h4); dats.push_back(8'(r));
      offs.push_back(4'h5); dats.push_back(crtc_tbl[m][r]);
    end
    offs.push_back(4'h8); dats.push_back(ctrl_tbl[m]);
    offs.push_back(4'h9); dats.push_back(color_tbl[m]);
    for (int i = 0; i < nreads; i++) begin
      e.k = k[0]; e.rd = 1'b1; e.a = io_addr(4'hA); e.d = 8'h00;
      exp_q.push_back(e);
    end
    for (int i = 0; i < nwrites; i++) begin
      e.k = k[0]; e.rd = 1'b0; e.a = io_addr(offs[i]); e.d = dats[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic finish_op(input int k, input bit rd, input logic [14:0] a, input logic [7:0] d,
                           input logic oe, input logic aen, input int width);
    op_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_op: dut%0d rd=%0b addr=%h data=%h, no op expected",
               k, rd, a, d);
      return;
    end
    e = exp_q.pop_front();
    ops_seen++;
    if (e.k != k[0] || e.rd != rd || e.a != a || (!rd && e.d != d) || width != T ||
        oe !== !rd || aen !== 1'b0) begin
      errors++;
      $display("FAIL bus_op: got dut%0d rd=%0b addr=%h data=%h oe=%0b aen=%0b width=%0d; expected dut%0d rd=%0b addr=%h data=%h oe=%0b aen=0 width=%0d",
               k, rd, a, d, oe, aen, width, e.k, e.rd, e.a, e.d, !e.rd, T);
    end
  endtask

  // Monitor: reconstructs each op from the strobes and scores it on strobe release
  initial begin
    bit          pw [2];
    bit          pr [2];
    int          lc [2];
    logic [14:0] ca [2];
    logic [7:0]  cd [2];
    logic        coe [2];
    logic        caen [2];
    for (int k = 0; k < 2; k++) begin
      pw[k] = 1'b1; pr[k] = 1'b1; lc[k] = 0; done_cnt[k] = 0; rd_cnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (nRESET !== 1'b1) begin
          // An op cut by reset is abandoned, never scored
          pw[k] = 1'b1; pr[k] = 1'b1; lc[k] = 0; rd_cnt[k] = 0;
        end else begin
          if (done[k] === 1'b1) done_cnt[k]++;
          if (bus_aen[k] === 1'b1) rd_cnt[k] = 0;
          if (bus_iow_l[k] === 1'b0 || bus_ior_l[k] === 1'b0) begin
            if (pw[k] && pr[k]) begin
              lc[k] = 1; ca[k] = bus_a[k]; cd[k] = bus_d[k];
              coe[k] = bus_oe[k]; caen[k] = bus_aen[k];
              if (bus_ior_l[k] === 1'b0) rd_cnt[k]++;
            end else begin
              lc[k]++;
            end
          end else if (!pw[k] || !pr[k]) begin
            finish_op(k, !pr[k], ca[k], cd[k], coe[k], caen[k], lc[k]);
          end
          pw[k] = (bus_iow_l[k] !== 1'b0);
          pr[k] = (bus_ior_l[k] !== 1'b0);
        end
      end
    end
  end

  // Start a sequence, optionally inject a start/mode change at cycle inj_at, wait for done
  task automatic run(input int k, input int m, input int inj_at, input int inj_mode,
                     output int lat);
    int d0;
    d0 = done_cnt[k];
    @(posedge clk); #1;
    start[k] = 1'b1; mode[k] = 2'(m);
    @(posedge clk); #1;
    start[k] = 1'b0;
    check($sformatf("busy_after_start_dut%0d", k), busy[k], 1'b1);
    check($sformatf("timeout_clear_on_start_dut%0d", k), timeout[k], 1'b0);
    lat = 1;  // counts clocks from the edge before the one that accepted start
    while (done[k] !== 1'b1 && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
      start[k] = (lat == inj_at);
      if (lat == inj_at) mode[k] = 2'(inj_mode);
    end
    start[k] = 1'b0;
    check($sformatf("done_seen_dut%0d", k), (lat < 3000), 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check($sformatf("single_done_dut%0d", k), done_cnt[k] - d0, 1);
    check($sformatf("ops_outstanding_dut%0d", k), exp_q.size(), 0);
    check($sformatf("idle_after_done_dut%0d", k), {busy[k], bus_aen[k]}, 2'b01);
    exp_q.delete();
  endtask

  initial begin
    int lat;
    int k;
    int m;
    int ga;
    int inj;
    int nreads;
    int base;
    int guard;
    int bad;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; mode[i] = 2'd0; good_after[i] = 1;
    end
    nRESET = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_values_dut%0d", i),
            {bus_iow_l[i], bus_ior_l[i], bus_aen[i], bus_oe[i], busy[i], done[i],
             timeout[i], bus_a[i], bus_d[i]}, {7'b1110000, 15'h0, 8'h0});
    nRESET = 1'b1;
    repeat (2) @(posedge clk);

    // 80x25 text, no retrace wait: full sequence and latency
    expect_seq(0, 1, 0, NumWrites);
    run(0, 1, 0, 0, lat);
    check("latency_mode1", lat, Latency);

    // 640x200, with a start and mode change injected mid-sequence
    expect_seq(0, 3, 0, NumWrites);
    run(0, 3, 100, 0, lat);
    check("latency_mode3_inject", lat, Latency);

    // Retrace found on the 4th status read
    good_after[1] = 4;
    expect_seq(1, 0, 4, NumWrites);
    run(1, 0, 0, 0, lat);
    check("timeout_after_retrace", timeout[1], 1'b0);

    // Retrace never seen: 4 reads, timeout, writes still happen
    good_after[1] = 1000;
    expect_seq(1, 1, 4, NumWrites);
    run(1, 1, 0, 0, lat);
    check("timeout_stuck", timeout[1], 1'b1);

    // Next start clears timeout; retrace present on the first read
    good_after[1] = 1;
    expect_seq(1, 2, 1, NumWrites);
    run(1, 2, 0, 0, lat);
    check("timeout_cleared", timeout[1], 1'b0);

    // Randomised runs across both instances
    for (int it = 0; it < 6; it++) begin
      k   = int'($urandom_range(0, 1));
      m   = int'($urandom_range(0, 3));
      ga  = int'($urandom_range(1, 6));
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 200)) : 0;
      nreads = 0;
      if (k == 1) begin
        good_after[1] = ga;
        nreads = (ga <= 4) ? ga : 4;
      end
      expect_seq(k, m, nreads, NumWrites);
      run(k, m, inj, int'($urandom_range(0, 3)), lat);
      if (k == 0) check($sformatf("latency_rand%0d", it), lat, Latency);
      else check($sformatf("timeout_rand%0d", it), timeout[1], (ga > 4));
    end

    // Reset in the middle of the strobe of step 5
    base = ops_seen;
    expect_seq(0, 2, 0, 5);
    @(posedge clk); #1;
    start[0] = 1'b1; mode[0] = 2'd2;
    @(posedge clk); #1;
    start[0] = 1'b0;
    guard = 0;
    while (!(ops_seen >= base + 5 && bus_iow_l[0] === 1'b0) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reached_step5_strobe", (guard < 500), 1'b1);
    @(posedge clk); #1;
    nRESET = 1'b0;
    #1;
    check("async_reset_bus", {bus_iow_l[0], bus_aen[0], busy[0], bus_oe[0]}, 4'b1100);
    repeat (3) @(posedge clk);
    #1;
    nRESET = 1'b1;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus_aen[0] !== 1'b1 || busy[0] !== 1'b0 || bus_iow_l[0] !== 1'b1) bad++;
    end
    check("no_resume_after_reset", bad, 0);
    check("ops_after_reset", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
